// File: rtl/char_rx_pkg.sv
// Shared types and constants for the char_rx serial byte receiver.
package char_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_e;

  localparam int DATA_BITS            = 8;
  localparam int BIT_IDX_W            = $clog2(DATA_BITS);
  localparam int CLKS_PER_BIT_DEFAULT = 16;
  localparam int CNT_W_DEFAULT        = $clog2(CLKS_PER_BIT_DEFAULT);

  // Cycle counter width for a given bit period.
  function automatic int cnt_width(input int clks_per_bit);
    return $clog2(clks_per_bit);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer with a configurable reset value.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/char_rx.sv
// 8N1 serial receiver: synchronizer, sampling FSM, shift register and a
// one-byte holding register with valid/ready output.
module char_rx
  import char_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rxd,
  output logic [7:0]      rx_data,
  output logic            rx_valid,
  input  logic            rx_ready,
  output logic            frame_err,
  output logic            overrun,
  output rx_state_e       state_dbg
);

  // Handshake: a byte transfers on any rising edge where rx_valid && rx_ready;
  // rx_valid never drops otherwise and rx_data is stable while it is high.

  localparam int CNT_W = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]     HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]     FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_IDX_W-1:0] BIT_LAST  = BIT_IDX_W'(DATA_BITS - 1);

  logic                 rxs;
  rx_state_e            state, state_d;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic [BIT_IDX_W-1:0] bit_idx, bit_d;
  logic [DATA_BITS-1:0] shreg;
  logic                 shift_en, good_stop, bad_stop;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rxd),
    .q     (rxs)
  );

  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      bit_idx <= bit_d;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt + 1'b1;
    bit_d     = bit_idx;
    shift_en  = 1'b0;
    good_stop = 1'b0;
    bad_stop  = 1'b0;
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (!rxs) state_d = START;
      end
      START: begin
        // Mid-start-bit check: a line already back high was only a glitch.
        if (cnt == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == FULL_LAST) begin
          cnt_d    = '0;
          shift_en = 1'b1;
          bit_d    = bit_idx + 1'b1;
          if (bit_idx == BIT_LAST) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt == FULL_LAST) begin
          cnt_d = '0;
          if (rxs) begin
            good_stop = 1'b1;
            state_d   = IDLE;
          end else begin
            bad_stop = 1'b1;
            state_d  = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        // A held-low (break) line must not retrigger reception.
        cnt_d = '0;
        if (rxs) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= bad_stop;
      overrun   <= 1'b0;
      if (shift_en) shreg <= {rxs, shreg[DATA_BITS-1:1]};
      if (good_stop) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_char_rx.sv
// Self-checking bench for char_rx: frame driver tasks, byte scoreboard,
// pulse counters and a final summary.
module tb_char_rx;
  import char_rx_pkg::*;

  localparam int N = 16;
  localparam int H = N / 2;
  localparam int VALID_LAT = 2 + H + 9 * N;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun;
  rx_state_e  state_dbg;

  logic [7:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int ferr_total = 0, ovr_total = 0, vcyc_total = 0;
  int last_rise = -1;
  logic prev_valid = 1'b0;

  char_rx #(.CLKS_PER_BIT(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .state_dbg (state_dbg)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard / monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) vcyc_total++;
      if (rx_valid && !prev_valid) last_rise = cyc;
      if (frame_err) ferr_total++;
      if (overrun) ovr_total++;
      if (frame_err || overrun) check("ferr_ovr_exclusive", 32'(frame_err & overrun), 32'd0);
      if (rx_valid && rx_ready) begin
        check("byte_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
      end
    end
    prev_valid = rst_n ? rx_valid : 1'b0;
  end

  // Driver tasks: entered and left just after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic v, input int cycles);
    rxd = v;
    idle(cycles);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, output int e0);
    e0 = cyc + 1;
    drive_bit(1'b0, N);
    for (int i = 0; i < DATA_BITS; i++) drive_bit(b[i], N);
    drive_bit(stop_bit, N);
    rxd = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_data"}, 32'(rx_data), 32'h00);
    check({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    check({tag, "_overrun"}, 32'(overrun), 32'd0);
    check({tag, "_state"}, 32'(state_dbg), 32'(IDLE));
  endtask

  initial begin
    int e0, fb, ob, vb;

    // 1. Reset
    rst_n = 1'b0;
    rxd = 1'b1;
    rx_ready = 1'b0;
    idle(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    fb = ferr_total; ob = ovr_total; vb = vcyc_total;
    idle(50);
    check("idle_valid_cycles", 32'(vcyc_total - vb), 32'd0);
    check("idle_frame_err", 32'(ferr_total - fb), 32'd0);
    check("idle_overrun", 32'(ovr_total - ob), 32'd0);

    // 2. Single frame
    rx_ready = 1'b1;
    vb = vcyc_total;
    exp_q.push_back(8'h61);
    send_byte(8'h61, 1'b1, e0);
    idle(10);
    check("single_latency", 32'(last_rise - e0), 32'(VALID_LAT));
    check("single_valid_cycles", 32'(vcyc_total - vb), 32'd1);
    check("single_q_drained", 32'(exp_q.size()), 32'd0);

    // 3. Overrun
    rx_ready = 1'b0;
    ob = ovr_total;
    exp_q.push_back(8'h48);
    send_byte(8'h48, 1'b1, e0);
    send_byte(8'h7A, 1'b1, e0);
    idle(5);
    check("ovr_pulses", 32'(ovr_total - ob), 32'd1);
    check("ovr_valid_held", 32'(rx_valid), 32'd1);
    check("ovr_data_held", 32'(rx_data), 32'h48);
    rx_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("ovr_valid_cleared", 32'(rx_valid), 32'd0);
    check("ovr_q_drained", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;

    // 4. Framing error with held-low line
    fb = ferr_total; vb = vcyc_total;
    send_byte(8'h3A, 1'b0, e0);
    drive_bit(1'b0, 40);
    check("ferr_wait_high", 32'(state_dbg), 32'(WAIT_HIGH));
    rxd = 1'b1;
    idle(20);
    check("ferr_pulses", 32'(ferr_total - fb), 32'd1);
    check("ferr_no_valid", 32'(vcyc_total - vb), 32'd0);
    check("ferr_back_idle", 32'(state_dbg), 32'(IDLE));

    // 5. Start glitch, then a held byte
    fb = ferr_total; vb = vcyc_total;
    drive_bit(1'b0, 3);
    rxd = 1'b1;
    idle(30);
    check("glitch_idle", 32'(state_dbg), 32'(IDLE));
    check("glitch_no_valid", 32'(vcyc_total - vb), 32'd0);
    check("glitch_no_ferr", 32'(ferr_total - fb), 32'd0);
    rx_ready = 1'b0;
    send_byte(8'h30, 1'b1, e0);
    idle(5);
    check("glitch_next_valid", 32'(rx_valid), 32'd1);
    check("glitch_next_data", 32'(rx_data), 32'h30);

    // 6. Reset during data bit 4 of 0x92
    begin
      logic [7:0] b;
      b = 8'h92;
      drive_bit(1'b0, N);
      for (int i = 0; i < 4; i++) drive_bit(b[i], N);
      drive_bit(b[4], H);
    end
    rst_n = 1'b0;
    rxd = 1'b1;
    #1;
    check_reset_outputs("midreset");
    idle(3);
    rst_n = 1'b1;
    idle(20);
    rx_ready = 1'b1;
    fb = ferr_total;
    exp_q.push_back(8'h7F);
    send_byte(8'h7F, 1'b1, e0);
    idle(10);
    check("after_reset_q_drained", 32'(exp_q.size()), 32'd0);
    check("after_reset_no_ferr", 32'(ferr_total - fb), 32'd0);
    check("after_reset_data", 32'(rx_data), 32'h7F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/char_rx.md
# char_rx

Serial byte receiver that sits directly upstream of the 8-bit ASCII case converter. It samples an asynchronous 8N1 serial line (one start bit, 8 data bits LSB first, one stop bit, idle high) and reassembles each frame into a byte. It presents each byte on an 8-bit bus with a valid/ready handshake, so the converter's `i7..i0` inputs are driven from `rx_data[7:0]`. It also reports framing errors and overruns.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit (N). Legal values: even and ≥ 4. Half-bit H = N/2.
- `clk`  in  1: single clock; all logic is on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `rxd`  in  1: asynchronous serial line, idle high.
- `rx_data`  out  8: received byte; `rx_data[7]` drives `i7` of the converter.
- `rx_valid`  out  1: `rx_data` holds an unconsumed byte.
- `rx_ready`  in  1: the consumer accepts the byte in a cycle where `rx_valid && rx_ready`.
- `frame_err`  out  1: one-cycle pulse when the stop bit is sampled low.
- `overrun`  out  1: one-cycle pulse when a good frame is dropped because the holding register is full.

## Operation
- Reset values:
  - `rx_data` = 0x00; `rx_valid`, `frame_err` and `overrun` = 0.
  - FSM in IDLE; bit counter and cycle counter = 0.
  - Both synchronizer flops = 1.
- `rxd` passes through a 2-flop synchronizer. The FSM sees only the synchronized value `rxs`.
- FSM states:
  - IDLE: when `rxs`==0, go to START with cnt=0.
  - START: count cnt 0..H-1. At cnt==H-1, sample `rxs`:
    - 0: go to DATA with cnt=0 and bit=0.
    - 1: the low was a glitch; return to IDLE.
  - DATA: count cnt 0..N-1. At cnt==N-1, shift `rxs` in as bit[bit], LSB first, and reset cnt.
    - After bit 7 is sampled, go to STOP.
  - STOP: count to cnt==N-1, then sample `rxs`:
    - 1: the frame is good; go to IDLE.
    - 0: pulse `frame_err`, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rxs`==1, then go to IDLE. This prevents a held-low line (break) from retriggering reception.
- Holding register, evaluated at the good-stop sample edge:
  - `rx_valid`==0: load `rx_data` and set `rx_valid`.
  - `rx_valid`==1 and `rx_ready`==1 in the same cycle: the old byte is consumed and the new byte is loaded; `rx_valid` stays 1.
  - `rx_valid`==1 and `rx_ready`==0: pulse `overrun`; drop the new byte; `rx_data` is unchanged.
- In every other cycle, `rx_valid && rx_ready` clears `rx_valid`. `rx_data` keeps its last value.
- `rx_data` only changes on a load.
- Reset mid-frame: the partial byte is lost and all outputs return to their reset values immediately, because reset is asynchronous.

## Timing
- Edge 0 is the first rising edge at which `rxd` is 0.
- Edge 2: FSM enters START.
- Edge 2+H: start bit is sampled.
- Edge 2+H+N·(i+1): data bit i is sampled, for i = 0..7.
- Edge 2+H+9N: stop bit is sampled.
- `rx_valid` / `frame_err` / `overrun` are visible after edge 2+H+9N. For N=16 this is edge 154.
- Bit sampling lands mid-bit for nominal baud.
- A back-to-back frame may start at IDLE on the cycle after the stop sample. No extra gap is required.
- Handshake:
  - `rx_valid` is never dropped without `rx_ready`.
  - `rx_data` is stable while `rx_valid` is high.
  - Throughput is one byte per frame.
- `frame_err` and `overrun` are never high in the same cycle.

## Structure
- Package `char_rx_pkg`:
  - state enum {IDLE, START, DATA, STOP, WAIT_HIGH};
  - constant `DATA_BITS` = 8;
  - constant for the cycle counter width, `$clog2(CLKS_PER_BIT)`.
- Sub-module `sync_2ff`: generic 1-bit two-flop synchronizer with a reset value parameter, here set to 1.
- The top level contains the FSM, counters, shift register and holding register.

## Test plan
1. **Reset:** assert `rst_n`=0 with `rxd`=1.
   - Required: `rx_data`=0x00 and `rx_valid`=`frame_err`=`overrun`=0.
   - Release reset and idle 50 cycles: no output activity.
2. **Single frame:** N=16, send 0x61 with `rx_ready`=1.
   - Required: `rx_valid` high after edge 154 for exactly 1 cycle, with `rx_data`=0x61.
3. **Overrun:** send 0x48 then 0x7A back-to-back with `rx_ready`=0.
   - Required: `rx_data`=0x48 is held, `overrun` pulses once at the second stop sample, and `rx_valid` stays 1.
   - Then raise `rx_ready`: `rx_valid` falls the next cycle.
4. **Framing error:** send 0x3A with the stop bit 0, then hold `rxd` low 40 cycles, then high.
   - Required: `frame_err` pulses once, `rx_valid` stays 0, and no further frame is started until `rxd` returns high.
5. **Start glitch:** drive `rxd` low for 3 cycles, then high.
   - Required: return to IDLE, no outputs.
   - Then a valid 0x30 frame is received correctly.
6. **Reset mid-frame:** assert `rst_n` during data bit 4 of 0x92.
   - Required: all outputs go to reset values immediately.
   - A following 0x7F frame yields `rx_data`=0x7F with no `frame_err`.
